// File: rtl/i2c_slave_pkg.sv
// Shared types and bus constants for the I2C register-interface slave.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/i2c_slave_cond_det.sv
// SCL/SDA synchronizer and bus-condition detector (START, STOP, SCL edges).
// Optional 3-sample majority filter enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_cond_det (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_smp,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_c, sda_c;

  // Stage p0/p1: two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl;
      scl_p1 <= scl_p0;
      sda_p0 <= sda;
      sda_p1 <= sda_p0;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] scl_hist, sda_hist;
  logic       scl_flt, sda_flt;

  // Filter stage: majority of the current and two previous samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_p1};
      sda_hist <= {sda_hist[0], sda_p1};
      scl_flt  <= maj3(scl_p1, scl_hist[0], scl_hist[1]);
      sda_flt  <= maj3(sda_p1, sda_hist[0], sda_hist[1]);
    end
  end

  assign scl_c = scl_flt;
  assign sda_c = sda_flt;
`else
  assign scl_c = scl_p1;
  assign sda_c = sda_p1;
`endif

  // Stage p2: one-cycle delay used only for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p2 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p2 <= scl_c;
      sda_p2 <= sda_c;
    end
  end

  assign sda_smp   = sda_c;
  assign scl_rise  = scl_c & ~scl_p2;
  assign scl_fall  = ~scl_c & scl_p2;
  assign start_det = scl_c & scl_p2 & sda_p2 & ~sda_c;
  assign stop_det  = scl_c & scl_p2 & ~sda_p2 & sda_c;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C slave bridging pointer-style byte transfers onto a single-cycle register port.
// Build option: I2C_SLAVE_GLITCH_FILTER_EN (majority filter in i2c_slave_cond_det).
module i2c_slave_regif
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h02,
  parameter int         AW         = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          scl_pad_i,
  input  logic          sda_pad_i,
  output logic          sda_pad_o,
  output logic          sda_padoen_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [7:0]    reg_wdata_o,
  output logic          reg_we_o,
  output logic          reg_re_o,
  input  logic [7:0]    reg_rdata_i,
  output logic          busy_o
);

  logic sda_smp, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_cond_det u_cond_det (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .scl       (scl_pad_i),
    .sda       (sda_pad_i),
    .sda_smp   (sda_smp),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rw;
  logic          mack;
  logic          rd_load;
  logic          sda_oe_n;
  logic [AW-1:0] ptr;
  logic [7:0]    wdata;
  logic          we;
  logic          re;
  logic          busy;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      rw       <= WRITE;
      mack     <= NACK;
      rd_load  <= 1'b0;
      sda_oe_n <= 1'b1;
      ptr      <= '0;
      wdata    <= 8'h00;
      we       <= 1'b0;
      re       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      we      <= 1'b0;
      re      <= 1'b0;
      rd_load <= re;
      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_n <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_n <= 1'b1;
        busy     <= 1'b0;
      end else begin
        // Read data arrives the cycle after the strobe; present its MSB at once.
        if (rd_load && state == RDATA) begin
          shreg    <= reg_rdata_i;
          sda_oe_n <= reg_rdata_i[7];
        end

        if (scl_rise) begin
          case (state)
            ADDR, PTR, WDATA: begin
              shreg   <= {shreg[6:0], sda_smp};
              bit_cnt <= bit_cnt + 4'd1;
            end
            RDATA:     bit_cnt <= bit_cnt + 4'd1;
            RDATA_ACK: mack    <= sda_smp;
            default: ;
          endcase
        end

        if (scl_fall) begin
          case (state)
            ADDR: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                if (shreg[7:1] == SLAVE_ADDR) begin
                  state    <= ADDR_ACK;
                  sda_oe_n <= ACK;
                  busy     <= 1'b1;
                  rw       <= shreg[0];
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
            ADDR_ACK: begin
              bit_cnt  <= 4'd0;
              sda_oe_n <= 1'b1;
              if (rw == READ) begin
                re    <= 1'b1;
                state <= RDATA;
              end else begin
                state <= PTR;
              end
            end
            PTR: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt  <= 4'd0;
                ptr      <= AW'(shreg);
                sda_oe_n <= ACK;
                state    <= PTR_ACK;
              end
            end
            PTR_ACK: begin
              sda_oe_n <= 1'b1;
              state    <= WDATA;
            end
            WDATA: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt  <= 4'd0;
                we       <= 1'b1;
                wdata    <= shreg;
                sda_oe_n <= ACK;
                state    <= WDATA_ACK;
              end
            end
            WDATA_ACK: begin
              sda_oe_n <= 1'b1;
              ptr      <= ptr + AW'(1);
              state    <= WDATA;
            end
            RDATA: begin
              if (bit_cnt == 4'd8) begin
                bit_cnt  <= 4'd0;
                sda_oe_n <= 1'b1;
                state    <= RDATA_ACK;
              end else begin
                shreg    <= {shreg[6:0], 1'b0};
                sda_oe_n <= shreg[6];
              end
            end
            RDATA_ACK: begin
              bit_cnt <= 4'd0;
              ptr     <= ptr + AW'(1);
              if (mack == ACK) begin
                re    <= 1'b1;
                state <= RDATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oe_n;
  assign reg_addr_o   = ptr;
  assign reg_wdata_o  = wdata;
  assign reg_we_o     = we;
  assign reg_re_o     = re;
  assign busy_o       = busy;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: bit-banged I2C master plus register-port monitor.
module tb_i2c_slave_regif;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_pad_o;
  logic       sda_padoen_o;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic       reg_re_o;
  logic [7:0] rdata_q = 8'h00;
  logic       busy_o;

  int n_checks = 0;
  int n_err    = 0;

  i2c_slave_regif #(.SLAVE_ADDR(7'h02), .AW(8)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .scl_pad_i    (scl),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_we_o     (reg_we_o),
    .reg_re_o     (reg_re_o),
    .reg_rdata_i  (rdata_q),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

  int         we_cnt = 0, re_cnt = 0, low_cnt = 0, both_cnt = 0;
  logic [7:0] we_a [0:31];
  logic [7:0] we_d [0:31];
  logic [7:0] re_a [0:31];

  // Register file model: data becomes valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (reg_re_o) begin
      case (reg_addr_o)
        8'h20:   rdata_q <= 8'h3C;
        8'h21:   rdata_q <= 8'hC3;
        default: rdata_q <= 8'hEE;
      endcase
    end
    if (reg_we_o) begin
      we_a[we_cnt[4:0]] <= reg_addr_o;
      we_d[we_cnt[4:0]] <= reg_wdata_o;
      we_cnt <= we_cnt + 1;
    end
    if (reg_re_o) begin
      re_a[re_cnt[4:0]] <= reg_addr_o;
      re_cnt <= re_cnt + 1;
    end
    if (reg_we_o && reg_re_o) both_cnt <= both_cnt + 1;
    if (!sda_padoen_o) low_cnt <= low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl   = 1'b1; tick(2 * Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    ack   = sda_bus; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(Q);
      scl   = 1'b1; tick(Q);
      d[i]  = sda_bus; tick(Q);
      scl   = 1'b0; tick(Q);
    end
    write_bit(mack);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] addr_w;
    int         bw, br, bl;

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    chk("rst_padoen", sda_padoen_o, 1);
    chk("rst_pad_o",  sda_pad_o, 0);
    chk("rst_addr",   reg_addr_o, 0);
    chk("rst_wdata",  reg_wdata_o, 0);
    chk("rst_we",     reg_we_o, 0);
    chk("rst_re",     reg_re_o, 0);
    chk("rst_busy",   busy_o, 0);

    // Write pointer 0x10 then two data bytes.
    bw = we_cnt;
    i2c_start();
    write_byte(8'h04, a); chk("wr_ack_addr", a, 0);
    write_byte(8'h10, a); chk("wr_ack_ptr", a, 0);
    write_byte(8'hA5, a); chk("wr_ack_d0", a, 0);
    write_byte(8'h5A, a); chk("wr_ack_d1", a, 0);
    chk("wr_busy_before_stop", busy_o, 1);
    i2c_stop();
    chk("wr_busy_after_stop", busy_o, 0);
    chk("wr_we_count", we_cnt - bw, 2);
    chk("wr_we0_addr", we_a[bw], 8'h10);
    chk("wr_we0_data", we_d[bw], 8'hA5);
    chk("wr_we1_addr", we_a[bw+1], 8'h11);
    chk("wr_we1_data", we_d[bw+1], 8'h5A);
    chk("wr_ptr_final", reg_addr_o, 8'h12);

    // Pointer set, repeated START, two-byte read.
    br = re_cnt;
    i2c_start();
    write_byte(8'h04, a); chk("rd_ack_addr_w", a, 0);
    write_byte(8'h20, a); chk("rd_ack_ptr", a, 0);
    i2c_start();
    write_byte(8'h05, a); chk("rd_ack_addr_r", a, 0);
    read_byte(1'b0, d);   chk("rd_byte0", d, 8'h3C);
    read_byte(1'b1, d);   chk("rd_byte1", d, 8'hC3);
    chk("rd_busy_after_nack", busy_o, 0);
    i2c_stop();
    chk("rd_re_count", re_cnt - br, 2);
    chk("rd_re0_addr", re_a[br], 8'h20);
    chk("rd_re1_addr", re_a[br+1], 8'h21);
    chk("rd_ptr_final", reg_addr_o, 8'h22);

    // Address mismatch: slave must stay silent.
    bw = we_cnt; br = re_cnt; bl = low_cnt;
    i2c_start();
    write_byte(8'h08, a); chk("mm_nack_addr", a, 1);
    chk("mm_busy", busy_o, 0);
    write_byte(8'h55, a); chk("mm_nack_data", a, 1);
    i2c_stop();
    chk("mm_sda_never_low", low_cnt - bl, 0);
    chk("mm_no_we", we_cnt - bw, 0);
    chk("mm_no_re", re_cnt - br, 0);

    // Pointer wrap from 0xFF to 0x00.
    bw = we_cnt;
    i2c_start();
    write_byte(8'h04, a);
    write_byte(8'hFF, a);
    write_byte(8'h11, a); chk("wrap_ack_d0", a, 0);
    write_byte(8'h22, a); chk("wrap_ack_d1", a, 0);
    i2c_stop();
    chk("wrap_we_count", we_cnt - bw, 2);
    chk("wrap_we0_addr", we_a[bw], 8'hFF);
    chk("wrap_we0_data", we_d[bw], 8'h11);
    chk("wrap_we1_addr", we_a[bw+1], 8'h00);
    chk("wrap_we1_data", we_d[bw+1], 8'h22);

    // STOP after four bits of a data byte, then a normal transaction.
    bw = we_cnt;
    i2c_start();
    write_byte(8'h04, a);
    write_byte(8'h30, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    chk("part_no_we", we_cnt - bw, 0);
    chk("part_sda_rel", sda_padoen_o, 1);
    chk("part_busy", busy_o, 0);
    i2c_start();
    write_byte(8'h04, a);
    write_byte(8'h40, a);
    write_byte(8'h77, a); chk("part_next_ack", a, 0);
    i2c_stop();
    chk("part_next_we_count", we_cnt - bw, 1);
    chk("part_next_addr", we_a[bw], 8'h40);
    chk("part_next_data", we_d[bw], 8'h77);

    // Reset while the slave is driving the address ACK.
    bw = we_cnt;
    addr_w = 8'h04;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
    sda_m = 1'b1; tick(Q);
    chk("rst_mid_ack_driven", sda_padoen_o, 0);
    chk("rst_mid_busy_before", busy_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_release", sda_padoen_o, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
    chk("rst_mid_busy_after", busy_o, 0);
    write_byte(8'h12, a); chk("rst_mid_ignored", a, 1);
    i2c_stop();
    chk("rst_mid_no_we", we_cnt - bw, 0);
    i2c_start();
    write_byte(8'h04, a); chk("rst_next_ack", a, 0);
    write_byte(8'h50, a);
    write_byte(8'h99, a);
    i2c_stop();
    chk("rst_next_we_count", we_cnt - bw, 1);
    chk("rst_next_addr", we_a[bw], 8'h50);
    chk("rst_next_data", we_d[bw], 8'h99);

    chk("never_we_and_re", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
